// File: rtl/bypass_scoreboard_if.sv
// bypass_scoreboard_if
// Decode-side bundle for the operand-bypass / hazard unit.
//   master : decode stage. Drives the issue slot, the source operands,
//            the register-file read data, the per-stage results and the
//            pipeline controls (ext_stall, flush).
//   slave  : bypass_scoreboard. Returns the resolved operands, the
//            forward flags, hazard_stall and stall_count.
// Parameters must match the bypass_scoreboard instance.
interface bypass_scoreboard_if #(
   parameter int NUM_SRC = 2,
   parameter int DEPTH   = 2,
   parameter int REG_W   = 5,
   parameter int DATA_W  = 32,
   parameter int LAT_W   = $clog2(DEPTH + 1)
);
   logic                               ext_stall;
   logic                               flush;
   logic                               iss_valid;
   logic                               iss_wen;
   logic [REG_W-1:0]                   iss_dst;
   logic [LAT_W-1:0]                   iss_lat;
   logic [NUM_SRC-1:0]                 src_used;
   logic [NUM_SRC-1:0][REG_W-1:0]      src_addr;
   logic [NUM_SRC-1:0][DATA_W-1:0]     src_rf_data;
   logic [DEPTH-1:0][DATA_W-1:0]       stage_val;
   logic [NUM_SRC-1:0][DATA_W-1:0]     src_data;
   logic [NUM_SRC-1:0]                 src_fwd;
   logic                               hazard_stall;
   logic [31:0]                        stall_count;

   modport master (
      output ext_stall, flush, iss_valid, iss_wen, iss_dst, iss_lat,
             src_used, src_addr, src_rf_data, stage_val,
      input  src_data, src_fwd, hazard_stall, stall_count
   );

   modport slave (
      input  ext_stall, flush, iss_valid, iss_wen, iss_dst, iss_lat,
             src_used, src_addr, src_rf_data, stage_val,
      output src_data, src_fwd, hazard_stall, stall_count
   );
endinterface

// File: rtl/bypass_scoreboard.sv
// bypass_scoreboard
// Operand-bypass and hazard unit between decode and the register file.
// Every in-flight register writer is tracked in a DEPTH-entry shift
// register {valid, dst, rem}, where rem is the number of cycles left before
// that stage's result is valid on stage_val. Each decode source takes its
// operand from the youngest matching producer (lowest index) or from the
// register file. If that producer is not ready yet and the source is
// actually read, decode is stalled.
// Ports:
//   clk    : clock
//   reset  : synchronous, active-high reset
//   bus    : bypass_scoreboard_if.slave. Carries the issue slot, the
//            sources, stage_val, ext_stall and flush in; and src_data,
//            src_fwd, hazard_stall and stall_count out.
// Build option:
//   BYPASS_STATS_EN : when defined, builds a saturating counter of cycles
//                     that stall the pipeline. Otherwise stall_count is 0.
module bypass_scoreboard #(
   parameter int NUM_SRC = 2,
   parameter int DEPTH   = 2,
   parameter int REG_W   = 5,
   parameter int DATA_W  = 32,
   parameter int LAT_W   = $clog2(DEPTH + 1)
) (
   input logic                clk,
   input logic                reset,
   bypass_scoreboard_if.slave bus
);

   logic             valid_r [DEPTH];
   logic [REG_W-1:0] dst_r   [DEPTH];
   logic [LAT_W-1:0] rem_r   [DEPTH];

   logic [NUM_SRC-1:0]             hit_s;
   logic [NUM_SRC-1:0]             ready_s;
   logic [NUM_SRC-1:0][DATA_W-1:0] fwd_val_s;
   logic [NUM_SRC-1:0][DATA_W-1:0] src_data_s;
   logic [NUM_SRC-1:0]             src_fwd_s;
   logic [NUM_SRC-1:0]             stall_src_s;
   logic                           hazard_s;
   logic [LAT_W-1:0]               lat_s;
   logic                           load_valid_s;

   // Find the youngest matching producer for each source. The walk goes from
   // oldest to youngest, so the last match found overrides any older one.
   always_comb begin
      hit_s     = {NUM_SRC{1'b0}};
      ready_s   = {NUM_SRC{1'b0}};
      fwd_val_s = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         for (int k = DEPTH - 1; k >= 0; k--) begin
            logic match_v;
            match_v = valid_r[k] && (dst_r[k] == bus.src_addr[i]) &&
                      (bus.src_addr[i] != {REG_W{1'b0}});
            ready_s[i]   = match_v ? (rem_r[k] == {LAT_W{1'b0}}) : ready_s[i];
            fwd_val_s[i] = match_v ? bus.stage_val[k] : fwd_val_s[i];
            hit_s[i]     = hit_s[i] | match_v;
         end
      end
   end

   // Choose each operand, and flag a stall for sources that are read while
   // their producer is not ready yet.
   always_comb begin
      src_data_s  = '0;
      src_fwd_s   = {NUM_SRC{1'b0}};
      stall_src_s = {NUM_SRC{1'b0}};
      for (int i = 0; i < NUM_SRC; i++) begin
         if (hit_s[i] && ready_s[i]) begin
            src_data_s[i] = fwd_val_s[i];
            src_fwd_s[i]  = 1'b1;
         end else begin
            src_data_s[i] = bus.src_rf_data[i];
            src_fwd_s[i]  = 1'b0;
         end
         stall_src_s[i] = hit_s[i] & ~ready_s[i] & bus.src_used[i];
      end
      hazard_s = bus.iss_valid & ~bus.flush & (|stall_src_s);
   end

   // Clamp the issue latency to the range 1..DEPTH. A latency of 0 is
   // treated as a 1-cycle op.
   always_comb begin
      if (bus.iss_lat == {LAT_W{1'b0}}) begin
         lat_s = LAT_W'(1);
      end else if (bus.iss_lat > LAT_W'(DEPTH)) begin
         lat_s = LAT_W'(DEPTH);
      end else begin
         lat_s = bus.iss_lat;
      end
      load_valid_s = bus.iss_valid & bus.iss_wen & ~bus.flush & ~hazard_s &
                     (bus.iss_dst != {REG_W{1'b0}});
   end

   // Advance the in-flight pipeline and load the new entry at stage 0. The
   // whole structure freezes while ext_stall is high.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int k = 0; k < DEPTH; k++) begin
            valid_r[k] <= 1'b0;
            dst_r[k]   <= {REG_W{1'b0}};
            rem_r[k]   <= {LAT_W{1'b0}};
         end
      end else if (!bus.ext_stall) begin
         for (int k = 1; k < DEPTH; k++) begin
            valid_r[k] <= valid_r[k-1];
            dst_r[k]   <= dst_r[k-1];
            rem_r[k]   <= (rem_r[k-1] == {LAT_W{1'b0}}) ? {LAT_W{1'b0}}
                                                        : rem_r[k-1] - LAT_W'(1);
         end
         valid_r[0] <= load_valid_s;
         dst_r[0]   <= bus.iss_dst;
         rem_r[0]   <= lat_s - LAT_W'(1);
      end
   end

   assign bus.src_data     = src_data_s;
   assign bus.src_fwd      = src_fwd_s;
   assign bus.hazard_stall = hazard_s;

`ifdef BYPASS_STATS_EN
   logic [31:0] stall_count_r;

   // Count cycles that actually hold decode. The count saturates at all-ones.
   always_ff @(posedge clk) begin
      if (reset) begin
         stall_count_r <= 32'd0;
      end else if (hazard_s && !bus.ext_stall && (stall_count_r != 32'hFFFF_FFFF)) begin
         stall_count_r <= stall_count_r + 32'd1;
      end
   end

   assign bus.stall_count = stall_count_r;
`else
   assign bus.stall_count = 32'd0;
`endif

endmodule

// File: tb/tb_bypass_scoreboard.sv
module tb_bypass_scoreboard;
   logic clk = 1'b0;
   logic reset;
   int   n_cmp = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   bypass_scoreboard_if bus ();
   bypass_scoreboard dut (.clk(clk), .reset(reset), .bus(bus));

   task automatic idle();
      bus.ext_stall      = 1'b0;
      bus.flush          = 1'b0;
      bus.iss_valid      = 1'b0;
      bus.iss_wen        = 1'b0;
      bus.iss_dst        = 5'd0;
      bus.iss_lat        = 2'd0;
      bus.src_used       = 2'b00;
      bus.src_addr       = '0;
      bus.src_rf_data[0] = 32'hAAAA_0001;
      bus.src_rf_data[1] = 32'hBBBB_0002;
      bus.stage_val      = '0;
   endtask

   task automatic issue(input logic [4:0] d, input logic [1:0] l);
      idle();
      bus.iss_valid = 1'b1;
      bus.iss_wen   = 1'b1;
      bus.iss_dst   = d;
      bus.iss_lat   = l;
   endtask

   task automatic rd(input logic [4:0] a0, input logic u0, input logic [4:0] a1, input logic u1);
      idle();
      bus.iss_valid   = 1'b1;
      bus.src_addr[0] = a0;
      bus.src_used[0] = u0;
      bus.src_addr[1] = a1;
      bus.src_used[1] = u1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      idle();
      bus.ext_stall = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      rd(5'd3, 1'b1, 5'd4, 1'b1);
      #1;
      n_cmp++; if (bus.hazard_stall !== 1'b0) begin n_bad++; $display("FAIL reset_hazard got %0b want 0", bus.hazard_stall); end
      n_cmp++; if (bus.src_fwd !== 2'b00) begin n_bad++; $display("FAIL reset_fwd got %b want 00", bus.src_fwd); end
      n_cmp++; if (bus.src_data[0] !== 32'hAAAA_0001) begin n_bad++; $display("FAIL reset_data0 got %h want aaaa0001", bus.src_data[0]); end
      n_cmp++; if (bus.src_data[1] !== 32'hBBBB_0002) begin n_bad++; $display("FAIL reset_data1 got %h want bbbb0002", bus.src_data[1]); end
      n_cmp++; if (bus.stall_count !== 32'd0) begin n_bad++; $display("FAIL reset_count got %0d want 0", bus.stall_count); end
   endtask

   task automatic test_alu_chain();
      @(negedge clk); issue(5'd3, 2'd1);
      @(negedge clk); rd(5'd3, 1'b1, 5'd9, 1'b1); bus.stage_val[0] = 32'h0000_1234;
      #1;
      n_cmp++; if (bus.src_data[0] !== 32'h0000_1234) begin n_bad++; $display("FAIL alu_data got %h want 00001234", bus.src_data[0]); end
      n_cmp++; if (bus.src_fwd !== 2'b01) begin n_bad++; $display("FAIL alu_fwd got %b want 01", bus.src_fwd); end
      n_cmp++; if (bus.hazard_stall !== 1'b0) begin n_bad++; $display("FAIL alu_hazard got %0b want 0", bus.hazard_stall); end
      n_cmp++; if (bus.src_data[1] !== 32'hBBBB_0002) begin n_bad++; $display("FAIL alu_rf1 got %h want bbbb0002", bus.src_data[1]); end
      // latency 0 behaves as a single-cycle op
      @(negedge clk); issue(5'd10, 2'd0);
      @(negedge clk); rd(5'd10, 1'b1, 5'd0, 1'b0); bus.stage_val[0] = 32'h0000_5A5A;
      #1;
      n_cmp++; if (bus.hazard_stall !== 1'b0) begin n_bad++; $display("FAIL lat0_hazard got %0b want 0", bus.hazard_stall); end
      n_cmp++; if (bus.src_data[0] !== 32'h0000_5A5A) begin n_bad++; $display("FAIL lat0_data got %h want 00005a5a", bus.src_data[0]); end
   endtask

   task automatic test_load_use();
      @(negedge clk); issue(5'd4, 2'd2);
      @(negedge clk); rd(5'd4, 1'b1, 5'd0, 1'b0);
      #1;
      n_cmp++; if (bus.hazard_stall !== 1'b1) begin n_bad++; $display("FAIL load_stall got %0b want 1", bus.hazard_stall); end
      @(negedge clk); bus.stage_val[1] = 32'hDEAD_BEEF;
      #1;
      n_cmp++; if (bus.hazard_stall !== 1'b0) begin n_bad++; $display("FAIL load_release got %0b want 0", bus.hazard_stall); end
      n_cmp++; if (bus.src_data[0] !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL load_data got %h want deadbeef", bus.src_data[0]); end
      n_cmp++; if (bus.src_fwd[0] !== 1'b1) begin n_bad++; $display("FAIL load_fwd got %0b want 1", bus.src_fwd[0]); end
      // latency 3 clamps to DEPTH=2, so the stall lasts one cycle
      @(negedge clk); issue(5'd11, 2'd3);
      @(negedge clk); rd(5'd11, 1'b1, 5'd0, 1'b0);
      #1;
      n_cmp++; if (bus.hazard_stall !== 1'b1) begin n_bad++; $display("FAIL clamp_stall got %0b want 1", bus.hazard_stall); end
      @(negedge clk); bus.stage_val[1] = 32'h0BAD_F00D;
      #1;
      n_cmp++; if (bus.hazard_stall !== 1'b0) begin n_bad++; $display("FAIL clamp_release got %0b want 0", bus.hazard_stall); end
      n_cmp++; if (bus.src_data[0] !== 32'h0BAD_F00D) begin n_bad++; $display("FAIL clamp_data got %h want 0badf00d", bus.src_data[0]); end
   endtask

   task automatic test_youngest();
      @(negedge clk); issue(5'd5, 2'd1);
      @(negedge clk); issue(5'd5, 2'd1);
      @(negedge clk); rd(5'd5, 1'b1, 5'd5, 1'b0);
      bus.stage_val[1] = 32'd1;
      bus.stage_val[0] = 32'd2;
      #1;
      n_cmp++; if (bus.src_data[0] !== 32'd2) begin n_bad++; $display("FAIL young_data0 got %h want 2", bus.src_data[0]); end
      n_cmp++; if (bus.src_data[1] !== 32'd2) begin n_bad++; $display("FAIL young_data1 got %h want 2", bus.src_data[1]); end
      n_cmp++; if (bus.src_fwd !== 2'b11) begin n_bad++; $display("FAIL young_fwd got %b want 11", bus.src_fwd); end
      // younger pending producer stalls even though an older one is ready
      @(negedge clk); issue(5'd12, 2'd1);
      @(negedge clk); issue(5'd12, 2'd2);
      @(negedge clk); rd(5'd12, 1'b1, 5'd0, 1'b0);
      #1;
      n_cmp++; if (bus.hazard_stall !== 1'b1) begin n_bad++; $display("FAIL young_pend got %0b want 1", bus.hazard_stall); end
      @(negedge clk); idle();
   endtask

   task automatic test_zero_unused();
      @(negedge clk); issue(5'd0, 2'd1);
      @(negedge clk); rd(5'd0, 1'b1, 5'd0, 1'b1); bus.src_rf_data[0] = 32'hCAFE_0000;
      #1;
      n_cmp++; if (bus.src_data[0] !== 32'hCAFE_0000) begin n_bad++; $display("FAIL zero_data got %h want cafe0000", bus.src_data[0]); end
      n_cmp++; if (bus.src_fwd !== 2'b00) begin n_bad++; $display("FAIL zero_fwd got %b want 00", bus.src_fwd); end
      n_cmp++; if (bus.hazard_stall !== 1'b0) begin n_bad++; $display("FAIL zero_hazard got %0b want 0", bus.hazard_stall); end
      @(negedge clk); issue(5'd6, 2'd2);
      @(negedge clk); rd(5'd6, 1'b0, 5'd6, 1'b0);
      #1;
      n_cmp++; if (bus.hazard_stall !== 1'b0) begin n_bad++; $display("FAIL unused_hazard got %0b want 0", bus.hazard_stall); end
      bus.src_used[1] = 1'b1;
      #1;
      n_cmp++; if (bus.hazard_stall !== 1'b1) begin n_bad++; $display("FAIL used_hazard got %0b want 1", bus.hazard_stall); end
      bus.flush = 1'b1;
      #1;
      n_cmp++; if (bus.hazard_stall !== 1'b0) begin n_bad++; $display("FAIL flush_hazard got %0b want 0", bus.hazard_stall); end
      @(negedge clk); idle();
   endtask

   task automatic test_freeze_reset();
      @(negedge clk); issue(5'd7, 2'd2);
      @(negedge clk); rd(5'd7, 1'b1, 5'd0, 1'b0); bus.ext_stall = 1'b1;
      #1;
      n_cmp++; if (bus.hazard_stall !== 1'b1) begin n_bad++; $display("FAIL freeze_stall0 got %0b want 1", bus.hazard_stall); end
      for (int c = 0; c < 3; c++) begin
         @(negedge clk); #1;
         n_cmp++; if (bus.hazard_stall !== 1'b1) begin n_bad++; $display("FAIL freeze_stall%0d got %0b want 1", c + 1, bus.hazard_stall); end
      end
      reset = 1'b1;
      @(negedge clk); reset = 1'b0;
      #1;
      n_cmp++; if (bus.hazard_stall !== 1'b0) begin n_bad++; $display("FAIL frz_rst_hazard got %0b want 0", bus.hazard_stall); end
      n_cmp++; if (bus.src_fwd !== 2'b00) begin n_bad++; $display("FAIL frz_rst_fwd got %b want 00", bus.src_fwd); end
      n_cmp++; if (bus.src_data[0] !== 32'hAAAA_0001) begin n_bad++; $display("FAIL frz_rst_data got %h want aaaa0001", bus.src_data[0]); end
      n_cmp++; if (bus.stall_count !== 32'd0) begin n_bad++; $display("FAIL frz_rst_count got %0d want 0", bus.stall_count); end
      @(negedge clk); idle();
   endtask

   task automatic test_stats();
      logic [31:0] exp_cnt;
`ifdef BYPASS_STATS_EN
      exp_cnt = 32'd5;
`else
      exp_cnt = 32'd0;
`endif
      for (int p = 0; p < 5; p++) begin
         @(negedge clk); issue(5'd8, 2'd2);
         @(negedge clk); rd(5'd8, 1'b1, 5'd0, 1'b0);
         #1;
         n_cmp++; if (bus.hazard_stall !== 1'b1) begin n_bad++; $display("FAIL stats_stall%0d got %0b want 1", p, bus.hazard_stall); end
         @(negedge clk); #1;
         n_cmp++; if (bus.hazard_stall !== 1'b0) begin n_bad++; $display("FAIL stats_rel%0d got %0b want 0", p, bus.hazard_stall); end
      end
      @(negedge clk); idle();
      #1;
      n_cmp++; if (bus.stall_count !== exp_cnt) begin n_bad++; $display("FAIL stats_count got %0d want %0d", bus.stall_count, exp_cnt); end
   endtask

   initial begin
      test_reset();
      test_alu_chain();
      test_load_use();
      test_youngest();
      test_zero_unused();
      test_freeze_reset();
      test_stats();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
